mor1kx_cache_refill: RTL

Critical-word-first line refill sequencer sitting directly upstream of the cache data RAM (simple dual-port RAM, single clock). It accepts a miss request and fetches one cache line from the bus beat by beat, starting at the missing word and wrapping within the line. Each acknowledged beat is driven onto the RAM write port in the same cycle. The critical word is also forwarded to the pipeline as soon as it arrives.

---
 rtl/mor1kx_cache_refill_pkg.sv | 10 +
 rtl/mor1kx_cache_refill.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/mor1kx_cache_refill_pkg.sv
// Shared types for the critical-word-first cache line refill sequencer.
// Holds the refill FSM state encoding.
package mor1kx_cache_refill_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_REFILL = 1'b1
  } refill_state_e;

endpackage

// File: rtl/mor1kx_cache_refill.sv
// Critical-word-first line refill sequencer feeding the cache data RAM.
// Ports: req_* miss request, bus_* beat fetch, mem_* RAM write, crit_*/done/err status.
module mor1kx_cache_refill
  import mor1kx_cache_refill_pkg::*;
#(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 32,
  parameter int BEATS_LOG2 = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic                  abort,
  output logic                  bus_req,
  output logic [ADDR_WIDTH-1:0] bus_adr,
  input  logic                  bus_ack,
  input  logic                  bus_err,
  input  logic [DATA_WIDTH-1:0] bus_dat_i,
  output logic [ADDR_WIDTH-1:0] mem_waddr,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_din,
  output logic                  crit_valid,
  output logic [DATA_WIDTH-1:0] crit_data,
  output logic                  done,
  output logic                  err
);

  localparam int BW = BEATS_LOG2;
  localparam int TW = ADDR_WIDTH - BEATS_LOG2;
  localparam logic [BW-1:0] CNT_LAST = {BW{1'b1}};

  refill_state_e         state_q, state_d;
  logic [TW-1:0]         base_q, base_d;
  logic [BW-1:0]         off_q, off_d;
  logic [BW-1:0]         cnt_q, cnt_d;
  logic                  bus_req_q, bus_req_d;
  logic [ADDR_WIDTH-1:0] bus_adr_q, bus_adr_d;
  logic                  crit_valid_q, crit_valid_d;
  logic [DATA_WIDTH-1:0] crit_data_q, crit_data_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;

  logic          in_refill;
  logic          beat_err;
  logic          beat_ok;
  logic [BW-1:0] off_inc;

  assign in_refill = (state_q == ST_REFILL);
  // Error beats win over ack and never reach the RAM.
  assign beat_err  = in_refill & bus_req_q & bus_err;
  assign beat_ok   = in_refill & bus_req_q & bus_ack & ~bus_err;
  // Offset wraps inside the line; it never carries into the base.
  assign off_inc   = off_q + 1'b1;

  always_comb begin
    state_d      = state_q;
    base_d       = base_q;
    off_d        = off_q;
    cnt_d        = cnt_q;
    bus_req_d    = bus_req_q;
    bus_adr_d    = bus_adr_q;
    crit_valid_d = 1'b0;
    crit_data_d  = crit_data_q;
    done_d       = 1'b0;
    err_d        = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          base_d    = req_addr[ADDR_WIDTH-1:BW];
          off_d     = req_addr[BW-1:0];
          cnt_d     = '0;
          bus_req_d = 1'b1;
          bus_adr_d = req_addr;
          state_d   = ST_REFILL;
        end
      end
      ST_REFILL: begin
        if (beat_err) begin
          bus_req_d = 1'b0;
          err_d     = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          if (beat_ok) begin
            off_d     = off_inc;
            bus_adr_d = {base_q, off_inc};
            cnt_d     = cnt_q + 1'b1;
            if (cnt_q == '0) begin
              crit_valid_d = 1'b1;
              crit_data_d  = bus_dat_i;
            end
            if (cnt_q == CNT_LAST) begin
              bus_req_d = 1'b0;
              done_d    = ~abort;
              state_d   = ST_IDLE;
            end
          end
          // An abort still lets a same-cycle ack land in the RAM.
          if (abort) begin
            bus_req_d = 1'b0;
            state_d   = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      base_q       <= '0;
      off_q        <= '0;
      cnt_q        <= '0;
      bus_req_q    <= 1'b0;
      bus_adr_q    <= '0;
      crit_valid_q <= 1'b0;
      crit_data_q  <= '0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      base_q       <= base_d;
      off_q        <= off_d;
      cnt_q        <= cnt_d;
      bus_req_q    <= bus_req_d;
      bus_adr_q    <= bus_adr_d;
      crit_valid_q <= crit_valid_d;
      crit_data_q  <= crit_data_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  assign req_ready  = ~in_refill;
  assign bus_req    = bus_req_q;
  assign bus_adr    = bus_adr_q;
  assign mem_waddr  = bus_adr_q;
  assign mem_we     = beat_ok;
  assign mem_din    = bus_dat_i;
  assign crit_valid = crit_valid_q;
  assign crit_data  = crit_data_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule
